// File: rtl/seq_mag_comp.sv
// ---------------------------------------------------------------------------
// seq_mag_comp
// Sequential magnitude comparator. Compares two WIDTH-bit operands SLICE bits
// per cycle, starting at the most significant slice, and stops as soon as a
// slice differs. Signed compares are folded into an unsigned compare by
// flipping the MSB of both operands when they are latched.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   in_valid     : operand pair offered
//   in_ready     : block can accept an operand pair (IDLE only)
//   A, B         : operands
//   signed_mode  : 1 = two's-complement compare, 0 = unsigned
//   out_valid    : result present (DONE only)
//   out_ready    : consumer takes the result
//   A_gt_b       : A > B
//   A_lt_b       : A < B
//   A_eq_b       : A == B
//   slices_used  : slices examined for the current result
// ---------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [WIDTH-1:0]                        A,
    input  logic [WIDTH-1:0]                        B,
    input  logic                                    signed_mode,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    A_gt_b,
    output logic                                    A_lt_b,
    output logic                                    A_eq_b,
    output logic [$clog2(WIDTH/SLICE+1)-1:0]        slices_used
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned UW     = $clog2(NSLICE + 1);
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDXW-1:0]    r_idx;
    logic [UW-1:0]      r_used;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_gt;
    logic               r_lt;
    logic               r_eq;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic               w_accept;
    logic [WIDTH-1:0]   w_flip;

    // Current slice pair under comparison
    assign w_a_sl   = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_b_sl   = r_b[int'(r_idx) * SLICE +: SLICE];
    assign w_accept = in_valid && r_in_ready && (r_state == S_IDLE);
    // Flipping the sign bit maps two's-complement order onto unsigned order
    assign w_flip   = signed_mode ? MSB_MASK : '0;

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_used      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= A ^ w_flip;
                        r_b        <= B ^ w_flip;
                        r_idx      <= IDXW'(NSLICE - 1);
                        r_used     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CMP;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_CMP: begin
                    r_used <= r_used + UW'(1);
                    if (w_a_sl > w_b_sl) begin
                        r_gt        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_a_sl < w_b_sl) begin
                        r_lt        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_eq        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                S_DONE: begin
                    // Result and slices_used hold until the consumer takes it
                    if (out_ready) begin
                        r_gt        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_eq        <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign A_gt_b      = r_gt;
    assign A_lt_b      = r_lt;
    assign A_eq_b      = r_eq;
    assign slices_used = r_used;

endmodule

// File: doc/seq_mag_comp.md
SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, giving the bits compared per cycle; WIDTH SHALL be a positive multiple of SLICE, and NSLICE = WIDTH/SLICE.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 Port A, input, WIDTH bits: first operand.
REQ-008 Port B, input, WIDTH bits: second operand.
REQ-009 Port signed_mode, input, 1 bit: 1 selects two's-complement compare, 0 selects unsigned.
REQ-010 Port out_valid, output, 1 bit: result is present.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 Port A_gt_b, output, 1 bit: A greater than B.
REQ-013 Port A_lt_b, output, 1 bit: A less than B.
REQ-014 Port A_eq_b, output, 1 bit: A equal to B.
REQ-015 Port slices_used, output, clog2(NSLICE+1) bits: number of slices examined for the current result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 The input handshake SHALL complete on a rising edge where in_valid=1 and in_ready=1.
REQ-019 On that edge the block SHALL latch A, B and signed_mode, set the slice index to NSLICE-1, clear slices_used to 0 and move to CMP.
REQ-020 When signed_mode=1, the block SHALL invert the MSB of both latched operands, making the comparison a pure unsigned compare.
REQ-021 In CMP, each cycle the block SHALL compare the latched slices [idx*SLICE +: SLICE] as unsigned values and increment slices_used.
REQ-022 If the slices differ, the block SHALL set A_gt_b or A_lt_b accordingly and move to DONE (early termination).
REQ-023 If the slices are equal and idx=0, the block SHALL set A_eq_b and move to DONE.
REQ-024 If the slices are equal and idx>0, the block SHALL decrement idx and stay in CMP.
REQ-025 out_valid SHALL be 1 only in DONE; it asserts k cycles after the accepting edge, where k = slices_used (1..NSLICE).
REQ-026 While out_valid=1, exactly one of A_gt_b, A_lt_b and A_eq_b SHALL be 1.
REQ-027 While out_valid=0, all three flags SHALL be 0.
REQ-028 In DONE, the flags and slices_used SHALL be held stable until a rising edge with out_ready=1; the block then returns to IDLE and the flags clear.
REQ-029 in_valid SHALL be ignored outside IDLE, and changes on A, B or signed_mode after acceptance SHALL NOT affect the result.
REQ-030 The block SHALL NOT accept a new pair in the same cycle it leaves DONE; one IDLE cycle minimum separates results.
REQ-031 slices_used SHALL hold its last value in IDLE until the next acceptance.

Reset
REQ-032 While rst=1, the block SHALL enter IDLE immediately, regardless of clock.
REQ-033 While rst=1, in_ready SHALL be 0, and SHALL become 1 on the first rising edge after rst deasserts.
REQ-034 While rst=1, out_valid, A_gt_b, A_lt_b, A_eq_b and slices_used SHALL be 0, and latched operands SHALL be cleared.
REQ-035 Reset asserted in CMP or DONE SHALL discard the in-flight compare; no result is produced for it.

Verification (WIDTH=16, SLICE=4)
REQ-036 The bench SHALL cover: A=0x1234, B=0x1235, signed_mode=0 -> out_valid 4 cycles after accept, A_lt_b=1, slices_used=4.
REQ-037 The bench SHALL cover: A=0x8000, B=0x0001, signed_mode=1 -> A_lt_b=1, slices_used=1; the same operands with signed_mode=0 -> A_gt_b=1, slices_used=1.
REQ-038 The bench SHALL cover: A=B=0xFFFF, signed_mode=1 -> A_eq_b=1, slices_used=4, out_valid 4 cycles after accept.
REQ-039 The bench SHALL cover: A=0x0500, B=0x0400, out_ready held 0 for 3 cycles -> A_gt_b=1 and slices_used=2 stable for all held cycles; in_ready=0 throughout; IDLE on the edge after out_ready=1.
REQ-040 The bench SHALL cover: in_valid pulsed with A=0, B=1 while in CMP for A=0x00F0, B=0x00F0 -> the second pair is ignored and the first result is A_eq_b=1.
REQ-041 The bench SHALL cover: rst asserted asynchronously mid-CMP -> outputs 0 with no clock edge, then in_ready=1 one edge after release and no stale out_valid.
